nx_bit_scan: RTL
================

# nx_bit_scan

Serialising set-bit scanner that sits directly downstream of `nx_clz`. It accepts a WIDTH-bit mask over a valid/ready handshake and holds it in a register. It then emits the index of every set bit, one per output handshake, in priority order. Each index is computed by an internal `nx_clz` instance driven from the held residual mask; emitted bits are cleared until the mask is exhausted. It is used wherever a sparse bitmap (pending signals, dirty flags) must be walked as a stream of indices.

## Interface
- `WIDTH`, 8, mask width in bits (≥2)
- `REVERSE`, 1'b0, 0: scan MSB-first; 1: scan LSB-first
- `IDX_WIDTH`, `$clog2(WIDTH)`, index width
- `clk_i`  in  1  clock
- `rstn_i`  in  1  reset, asynchronous, active-low
- `in_mask_i`  in  WIDTH  mask to scan
- `in_valid_i`  in  1  mask valid
- `in_ready_o`  out  1  block can accept mask
- `out_index_o`  out  IDX_WIDTH  bit position of current set bit
- `out_ordinal_o`  out  IDX_WIDTH+1  0-based count of beats already emitted for this mask
- `out_empty_o`  out  1  mask was all zero (index invalid)
- `out_last_o`  out  1  final beat for this mask
- `out_valid_o`  out  1  output beat valid
- `out_ready_i`  in  1  downstream accepts beat

## Operation
- Clock `clk_i`, one domain; reset `rstn_i` asynchronous, active-low.
- State machine: IDLE, SCAN.
  - IDLE: `in_ready_o`=1, `out_valid_o`=0. On `in_valid_i && in_ready_o`: residual <= `in_mask_i`, ordinal <= 0, go SCAN.
  - SCAN: `out_valid_o`=1.
    - If residual != 0: clz = `nx_clz(residual, REVERSE_INPUT=REVERSE)`.
    - `out_index_o` = WIDTH-1-clz when REVERSE=0, clz when REVERSE=1.
    - `out_empty_o`=0; `out_last_o`=1 iff residual has exactly one bit set.
  - SCAN with residual == 0 (zero mask only): `out_empty_o`=1, `out_last_o`=1, `out_index_o`=0.
- On output handshake (`out_valid_o && out_ready_i`):
  - Clear bit `out_index_o` in residual and increment ordinal.
  - If `out_last_o`: go IDLE, unless a new mask is accepted in the same cycle (see below).
- Reload: `in_ready_o` = IDLE || (`out_valid_o && out_last_o && out_ready_i`). This is a combinational path from `out_ready_i`. On reload, the new mask loads into residual, ordinal <= 0, and the state stays SCAN.
- Stall: while `out_valid_o && !out_ready_i`, all out_* outputs, the residual and the ordinal are held stable.
- `out_valid_o` never drops without a handshake.
- Arithmetic: ordinal counts 0..WIDTH-1 and never wraps within one mask. The clz count (width IDX_WIDTH+1) is truncated to IDX_WIDTH only after subtraction. Residual is non-zero in that case, so clz ≤ WIDTH-1.

## Timing
- Reset values: state IDLE, residual 0, ordinal 0.
- Outputs during and after reset: `in_ready_o`=1, `out_valid_o`=0, `out_index_o`=0, `out_ordinal_o`=0, `out_empty_o`=0, `out_last_o`=0.
- Latency: mask accepted at edge N → first beat valid in cycle N+1.
- Throughput: one index per cycle with `out_ready_i` held high. A mask with k set bits occupies k cycles (zero mask: 1 cycle).
- Back-to-back masks: no bubble when the next mask is presented during the last beat.
- Outside the reload cycle, `in_ready_o`=0 while in SCAN.
- Reset asserted mid-scan: residual discarded, outputs return to reset values immediately. No beat is emitted for the discarded mask.

## Test plan
- WIDTH=8, REVERSE=0, mask 8'b1001_0010, `out_ready_i`=1 → indices 7,4,1 in consecutive cycles. Ordinals 0,1,2; last=1 only on index 1; `in_ready_o` low for the first two beats.
- REVERSE=1, same mask → indices 1,4,7, last on 7.
- Mask 8'h00 → single beat: empty=1, last=1, index 0, ordinal 0; then IDLE.
- Mask 8'hFF with `out_ready_i` low for 3 cycles on the first beat → index 7 and ordinal 0 held stable for 4 cycles. Then indices 6..0 follow, last on 0.
- Mask 8'h81, second mask 8'h01 held valid throughout → second mask accepted on the edge of the index-0 beat. The next cycle shows index 0, ordinal 0, last=1 with no idle cycle.
- Mask 8'hF0, `rstn_i` pulsed low after the first beat → `out_valid_o`=0 and `in_ready_o`=1 immediately. No further beats for 8'hF0.

Source files
------------

// File: rtl/nx_bit_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nx_bit_scan : walks a held mask and emits one set-bit index per beat.       |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+

module nx_clz #(
   parameter int WIDTH         = 8,
   parameter bit REVERSE_INPUT = 1'b0,
   parameter int CNT_W         = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [WIDTH-1:0] reversed;
   logic [WIDTH-1:0] scan_vec;

   for (genvar g = 0; g < WIDTH; g++) begin : g_rev
      assign reversed[g] = data_i[WIDTH-1-g];
   end

   assign scan_vec = REVERSE_INPUT ? reversed : data_i;

   // Walking upward lets the highest set bit overwrite any lower one.
   always_comb begin
      cnt_o = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (scan_vec[i]) begin
            cnt_o = CNT_W'(WIDTH - 1 - i);
         end
      end
   end

endmodule

module nx_bit_scan #(
   parameter int WIDTH     = 8,
   parameter bit REVERSE   = 1'b0,
   parameter int IDX_WIDTH = $clog2(WIDTH)
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [WIDTH-1:0]     in_mask_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [IDX_WIDTH-1:0] out_index_o,
   output logic [IDX_WIDTH:0]   out_ordinal_o,
   output logic                 out_empty_o,
   output logic                 out_last_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   localparam logic [IDX_WIDTH:0] MSB_POS = (IDX_WIDTH + 1)'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     residual_q, residual_d;
   logic [IDX_WIDTH:0]   ordinal_q, ordinal_d;

   logic [IDX_WIDTH:0]   clz_cnt;
   logic [IDX_WIDTH:0]   idx_full;
   logic                 idx_msb_unused;
   logic [IDX_WIDTH-1:0] scan_idx;
   logic                 res_empty;
   logic                 res_one_hot;
   logic                 in_scan;
   logic                 beat_last;
   logic                 out_fire;
   logic                 in_fire;

   nx_clz #(
      .WIDTH         (WIDTH),
      .REVERSE_INPUT (REVERSE),
      .CNT_W         (IDX_WIDTH + 1)
   ) u_clz (
      .data_i (residual_q),
      .cnt_o  (clz_cnt)
   );

   // Subtract at full width, then drop the top bit; residual is non-zero whenever this is used.
   assign idx_full       = REVERSE ? clz_cnt : (MSB_POS - clz_cnt);
   assign scan_idx       = idx_full[IDX_WIDTH-1:0];
   assign idx_msb_unused = idx_full[IDX_WIDTH];

   assign res_empty   = (residual_q == '0);
   assign res_one_hot = !res_empty && ((residual_q & (residual_q - 1'b1)) == '0);
   assign in_scan     = (state_q == S_SCAN);
   assign beat_last   = res_empty || res_one_hot;

   assign out_valid_o   = in_scan;
   assign out_empty_o   = in_scan && res_empty;
   assign out_last_o    = in_scan && beat_last;
   assign out_index_o   = (in_scan && !res_empty) ? scan_idx : '0;
   assign out_ordinal_o = in_scan ? ordinal_q : '0;

   assign out_fire   = in_scan && out_ready_i;
   // Ready reaches back combinationally so a new mask can follow the last beat without a bubble.
   assign in_ready_o = !in_scan || (beat_last && out_ready_i);
   assign in_fire    = in_valid_i && in_ready_o;

   always_comb begin
      state_d    = state_q;
      residual_d = residual_q;
      ordinal_d  = ordinal_q;
      if (out_fire) begin
         residual_d = residual_q & ~(WIDTH'(1) << scan_idx);
         ordinal_d  = ordinal_q + 1'b1;
         if (beat_last) begin
            state_d = S_IDLE;
         end
      end
      if (in_fire) begin
         state_d    = S_SCAN;
         residual_d = in_mask_i;
         ordinal_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         residual_q <= '0;
         ordinal_q  <= '0;
      end else begin
         state_q    <= state_d;
         residual_q <= residual_d;
         ordinal_q  <= ordinal_d;
      end
   end

endmodule
`default_nettype wire
